ram_port_arbiter: RTL and testbench

//  Shares the single byte-addressable data RAM port between instruction fetch (M0, word reads only) and the
//  MEM stage (M1, load/store with u_b_h_w width code). It sits between the core and the RAM and drives its

---
 rtl/ram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one byte-addressable RAM port between instruction
// fetch (M0, word reads) and the MEM stage (M1, loads/stores). M1 has fixed
// priority; a saturating starvation counter forces an M0 grant after
// STARVE_LIMIT consecutive M1 wins while M0 is waiting.
// Optional build macro RAM_ARB_PERF_CNT_EN adds grant/wait performance counters.
module ram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_ubhw,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic [2:0]  ram_ubhw,
  input  logic [31:0] ram_rdata
`ifdef RAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_m0_gnt,
  output logic [31:0] perf_m1_gnt,
  output logic [31:0] perf_m0_wait
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT0 = 2'd1;
  localparam logic [1:0] S_GNT1 = 2'd2;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [31:0]      r_m0_addr;
  logic [31:0]      r_m1_addr;
  logic [31:0]      r_m1_wdata;
  logic             r_m1_we;
  logic [2:0]       r_m1_ubhw;

  logic w_starved;
  logic w_win0;
  logic w_win1;

  assign w_starved = m0_req && (r_starve_cnt == LIMIT);
  assign w_win1    = m1_req && !w_starved;
  assign w_win0    = !w_win1 && m0_req;

  // Arbitrate every edge, latch the winner's request and track M0 starvation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_m0_addr    <= '0;
      r_m1_addr    <= '0;
      r_m1_wdata   <= '0;
      r_m1_we      <= 1'b0;
      r_m1_ubhw    <= '0;
    end else begin
      if (w_win1) begin
        r_state    <= S_GNT1;
        r_m1_addr  <= m1_addr;
        r_m1_wdata <= m1_wdata;
        r_m1_we    <= m1_we;
        r_m1_ubhw  <= m1_ubhw;
      end else if (w_win0) begin
        r_state   <= S_GNT0;
        r_m0_addr <= m0_addr;
      end else begin
        r_state <= S_IDLE;
      end

      // An M1 win with M0 pending can only happen below LIMIT, so this saturates
      if (!m0_req || w_win0) begin
        r_starve_cnt <= '0;
      end else if (w_win1 && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // Drive the RAM and the acks purely from the state and the latched request
  always_comb begin
    m0_ack    = 1'b0;
    m0_rdata  = '0;
    m1_ack    = 1'b0;
    m1_rdata  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_ubhw  = '0;
    case (r_state)
      S_GNT0: begin
        ram_addr = r_m0_addr;
        ram_ubhw = 3'b010;
        m0_ack   = 1'b1;
        m0_rdata = ram_rdata;
      end
      S_GNT1: begin
        ram_addr  = r_m1_addr;
        ram_wdata = r_m1_wdata;
        ram_we    = r_m1_we;
        ram_ubhw  = r_m1_ubhw;
        m1_ack    = 1'b1;
        m1_rdata  = r_m1_we ? '0 : ram_rdata;
      end
      default: begin
      end
    endcase
  end

`ifdef RAM_ARB_PERF_CNT_EN
  logic [31:0] r_perf_m0_gnt;
  logic [31:0] r_perf_m1_gnt;
  logic [31:0] r_perf_m0_wait;

  // Counters step on entry to each cycle, so their value already includes the current cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_m0_gnt  <= '0;
      r_perf_m1_gnt  <= '0;
      r_perf_m0_wait <= '0;
    end else begin
      if (w_win0)            r_perf_m0_gnt  <= r_perf_m0_gnt + 32'd1;
      if (w_win1)            r_perf_m1_gnt  <= r_perf_m1_gnt + 32'd1;
      if (m0_req && !w_win0) r_perf_m0_wait <= r_perf_m0_wait + 32'd1;
    end
  end

  assign perf_m0_gnt  = r_perf_m0_gnt;
  assign perf_m1_gnt  = r_perf_m1_gnt;
  assign perf_m0_wait = r_perf_m0_wait;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a byte RAM environment plus a transaction-level
// reference model (grant rule, wait streak count, shadow memory).
module tb_ram_port_arbiter;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [2:0]  m1_ubhw;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [2:0]  ram_ubhw;
  logic [31:0] ram_rdata;
`ifdef RAM_ARB_PERF_CNT_EN
  logic [31:0] perf_m0_gnt;
  logic [31:0] perf_m1_gnt;
  logic [31:0] perf_m0_wait;
`endif

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ubhw(m1_ubhw), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_ubhw(ram_ubhw), .ram_rdata(ram_rdata)
`ifdef RAM_ARB_PERF_CNT_EN
    , .perf_m0_gnt(perf_m0_gnt), .perf_m1_gnt(perf_m1_gnt), .perf_m0_wait(perf_m0_wait)
`endif
  );

  always #5 clk = ~clk;

  // Width/sign handling of the RAM's mem_u_b_h_w code {unsigned, word, half}
  function automatic logic [31:0] extend(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [2:0] u);
    if (u[1]) return {b3, b2, b1, b0};
    if (u[0]) return u[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
    return u[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
  endfunction

  function automatic logic [7:0] init_byte(input int unsigned i);
    if (i == 32'h10) return 8'hEF;
    if (i == 32'h11) return 8'hBE;
    if (i == 32'h12) return 8'hAD;
    if (i == 32'h13) return 8'hDE;
    if (i == 32'h30) return 8'h11;
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // RAM environment: combinational read, store commits on negedge
  logic [7:0] tb_mem [0:1023];
  always_comb ram_rdata = extend(tb_mem[ram_addr[9:0]], tb_mem[ram_addr[9:0] + 10'd1],
                                 tb_mem[ram_addr[9:0] + 10'd2], tb_mem[ram_addr[9:0] + 10'd3],
                                 ram_ubhw);
  initial begin
    for (int unsigned i = 0; i < 1024; i++) tb_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (ram_we) begin
        tb_mem[ram_addr[9:0]] = ram_wdata[7:0];
        if (ram_ubhw[1] || ram_ubhw[0]) tb_mem[ram_addr[9:0] + 10'd1] = ram_wdata[15:8];
        if (ram_ubhw[1]) begin
          tb_mem[ram_addr[9:0] + 10'd2] = ram_wdata[23:16];
          tb_mem[ram_addr[9:0] + 10'd3] = ram_wdata[31:24];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  mdl_mem [0:1023];
  int unsigned mdl_losses;          // consecutive M1 wins while M0 was waiting
  int unsigned mdl_m0_gnt, mdl_m1_gnt, mdl_m0_wait;
  bit          pend_st;
  logic [31:0] pend_addr, pend_data;
  logic [2:0]  pend_u;
  logic        e_m0_ack, e_m1_ack, e_ram_we;
  logic [31:0] e_m0_rdata, e_m1_rdata, e_ram_addr;

  function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic [2:0] u);
    logic [9:0] i;
    i = a[9:0];
    return extend(mdl_mem[i], mdl_mem[i + 10'd1], mdl_mem[i + 10'd2], mdl_mem[i + 10'd3], u);
  endfunction

  task automatic mdl_commit();
    logic [9:0] i;
    int unsigned n;
    if (pend_st) begin
      i = pend_addr[9:0];
      n = pend_u[1] ? 4 : (pend_u[0] ? 2 : 1);
      for (int unsigned k = 0; k < n; k++) mdl_mem[i + 10'(k)] = 8'(pend_data >> (8 * k));
      pend_st = 0;
    end
  endtask

  task automatic model_reset();
    mdl_losses = 0; mdl_m0_gnt = 0; mdl_m1_gnt = 0; mdl_m0_wait = 0;
    pend_st = 0;
    e_m0_ack = 0; e_m1_ack = 0; e_ram_we = 0;
    e_m0_rdata = '0; e_m1_rdata = '0; e_ram_addr = '0;
  endtask

  // Advance one clock: predict who owns the port for the coming cycle; returns #1 after the edge
  task automatic model_edge();
    logic q0, q1, we;
    logic [31:0] a0, a1, wd;
    logic [2:0] u;
    q0 = m0_req; q1 = m1_req; we = m1_we; a0 = m0_addr; a1 = m1_addr; wd = m1_wdata; u = m1_ubhw;
    @(posedge clk);
    mdl_commit();
    e_m0_ack = 0; e_m1_ack = 0; e_ram_we = 0;
    e_m0_rdata = '0; e_m1_rdata = '0; e_ram_addr = '0;
    if (q1 && !(q0 && mdl_losses >= LIMIT)) begin
      e_m1_ack = 1; e_ram_addr = a1; e_ram_we = we;
      if (we) begin
        pend_st = 1; pend_addr = a1; pend_data = wd; pend_u = u;
      end else begin
        e_m1_rdata = mdl_read(a1, u);
      end
      mdl_m1_gnt++;
      if (q0) begin
        mdl_m0_wait++;
        if (mdl_losses < LIMIT) mdl_losses++;
      end else begin
        mdl_losses = 0;
      end
    end else if (q0) begin
      e_m0_ack = 1; e_ram_addr = a0; e_m0_rdata = mdl_read(a0, 3'b010);
      mdl_m0_gnt++;
      mdl_losses = 0;
    end else begin
      mdl_losses = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m0_addr = 32'h44; m1_addr = 32'h88; m1_wdata = 32'hFFFF_FFFF; m1_we = 1'b1; m1_ubhw = 3'b010;
    rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    model_reset();
    #2;
    checks++; if (m0_ack !== 1'b0) $display("FAIL reset_m0_ack got %0h want 0", m0_ack);
    if (m0_ack !== 1'b0) errors++;
    checks++; if (m1_ack !== 1'b0) begin $display("FAIL reset_m1_ack got %0h want 0", m1_ack); errors++; end
    checks++; if (ram_we !== 1'b0) begin $display("FAIL reset_ram_we got %0h want 0", ram_we); errors++; end
    checks++; if (ram_addr !== 32'h0) begin $display("FAIL reset_ram_addr got %0h want 0", ram_addr); errors++; end
    checks++; if (ram_wdata !== 32'h0) begin $display("FAIL reset_ram_wdata got %0h want 0", ram_wdata); errors++; end
    checks++; if (ram_ubhw !== 3'h0) begin $display("FAIL reset_ram_ubhw got %0h want 0", ram_ubhw); errors++; end
    checks++; if (m0_rdata !== 32'h0) begin $display("FAIL reset_m0_rdata got %0h want 0", m0_rdata); errors++; end
    checks++; if (m1_rdata !== 32'h0) begin $display("FAIL reset_m1_rdata got %0h want 0", m1_rdata); errors++; end
    do_reset();
  endtask

  task automatic test_m0_only();
    m0_addr = 32'h10; m0_req = 1'b1;
    model_edge();
    m0_req = 1'b0;
    checks++; if (m0_ack !== 1'b1) begin $display("FAIL m0only_ack got %0h want 1", m0_ack); errors++; end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin $display("FAIL m0only_rdata got %0h want deadbeef", m0_rdata); errors++; end
    checks++; if (ram_we !== 1'b0) begin $display("FAIL m0only_we got %0h want 0", ram_we); errors++; end
    checks++; if (ram_addr !== 32'h10) begin $display("FAIL m0only_addr got %0h want 10", ram_addr); errors++; end
    checks++; if (ram_ubhw !== 3'b010) begin $display("FAIL m0only_ubhw got %0h want 2", ram_ubhw); errors++; end
    model_edge();
    checks++; if (m0_ack !== 1'b0) begin $display("FAIL m0only_release got %0h want 0", m0_ack); errors++; end
  endtask

  task automatic test_store_load();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h80; m1_ubhw = 3'b000;
    model_edge();
    checks++; if (m1_ack !== 1'b1) begin $display("FAIL sb_ack got %0h want 1", m1_ack); errors++; end
    checks++; if (ram_we !== 1'b1) begin $display("FAIL sb_we got %0h want 1", ram_we); errors++; end
    checks++; if (ram_addr !== 32'h20) begin $display("FAIL sb_addr got %0h want 20", ram_addr); errors++; end
    checks++; if (ram_wdata[7:0] !== 8'h80) begin $display("FAIL sb_wdata got %0h want 80", ram_wdata[7:0]); errors++; end
    checks++; if (m1_rdata !== 32'h0) begin $display("FAIL sb_rdata got %0h want 0", m1_rdata); errors++; end
    m1_we = 1'b0; m1_wdata = 32'h0;
    model_edge();
    checks++; if (m1_ack !== 1'b1) begin $display("FAIL lb_ack got %0h want 1", m1_ack); errors++; end
    checks++; if (ram_we !== 1'b0) begin $display("FAIL lb_we got %0h want 0", ram_we); errors++; end
    checks++; if (m1_rdata !== 32'hFFFFFF80) begin $display("FAIL lb_rdata got %0h want ffffff80", m1_rdata); errors++; end
    m1_ubhw = 3'b100;
    model_edge();
    m1_req = 1'b0;
    checks++; if (m1_rdata !== 32'h00000080) begin $display("FAIL lbu_rdata got %0h want 80", m1_rdata); errors++; end
    model_edge();
  endtask

  task automatic test_contention();
    int pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    m0_addr = 32'h10; m1_addr = 32'h14; m1_we = 1'b0; m1_ubhw = 3'b010;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      model_edge();
      checks++;
      if (m1_ack !== 1'(pat[i]) || m0_ack !== 1'(1 - pat[i])) begin
        $display("FAIL contention_grant[%0d] got m1_ack=%0h m0_ack=%0h want m1_ack=%0h", i, m1_ack, m0_ack, pat[i]);
        errors++;
      end
      checks++;
      if (m0_rdata !== e_m0_rdata || m1_rdata !== e_m1_rdata) begin
        $display("FAIL contention_rdata[%0d] got %0h/%0h want %0h/%0h", i, m0_rdata, m1_rdata, e_m0_rdata, e_m1_rdata);
        errors++;
      end
    end
`ifdef RAM_ARB_PERF_CNT_EN
    checks++; if (perf_m1_gnt !== 32'd8) begin $display("FAIL perf_m1_gnt got %0d want 8", perf_m1_gnt); errors++; end
    checks++; if (perf_m0_gnt !== 32'd2) begin $display("FAIL perf_m0_gnt got %0d want 2", perf_m0_gnt); errors++; end
    checks++; if (perf_m0_wait !== 32'd8) begin $display("FAIL perf_m0_wait got %0d want 8", perf_m0_wait); errors++; end
`endif
    do_reset();
  endtask

  task automatic test_idle_return();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_ubhw = 3'b010;
    model_edge();
    m1_req = 1'b0;
    checks++; if (m1_ack !== 1'b1) begin $display("FAIL idle_gnt1_ack got %0h want 1", m1_ack); errors++; end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin $display("FAIL idle_gnt1_rdata got %0h want deadbeef", m1_rdata); errors++; end
    for (int i = 0; i < 2; i++) begin
      model_edge();
      checks++;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0 || m1_rdata !== 32'h0) begin
        $display("FAIL idle_state[%0d] got acks=%0h%0h we=%0h addr=%0h rdata=%0h want all 0",
                 i, m0_ack, m1_ack, ram_we, ram_addr, m1_rdata);
        errors++;
      end
    end
  endtask

  task automatic test_async_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h5A; m1_ubhw = 3'b000;
    model_edge();
    checks++; if (ram_we !== 1'b1) begin $display("FAIL arst_store_we got %0h want 1", ram_we); errors++; end
    rst = 1'b1; m1_req = 1'b0;
    model_reset();
    #1;
    checks++; if (ram_we !== 1'b0) begin $display("FAIL arst_we_drop got %0h want 0", ram_we); errors++; end
    checks++; if (m1_ack !== 1'b0) begin $display("FAIL arst_ack_drop got %0h want 0", m1_ack); errors++; end
    @(posedge clk);
    #1 rst = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_ubhw = 3'b100;
    model_edge();
    m1_req = 1'b0;
    checks++; if (m1_rdata !== 32'h11) begin $display("FAIL arst_byte_kept got %0h want 11", m1_rdata); errors++; end
    model_edge();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom_range(0, 1023);
    if ($urandom_range(0, 7) == 0) a = 32'h1000_0000 | a;
    return a;
  endfunction

  task automatic test_random();
    logic [2:0] ut [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    m0_req = 1'b0; m1_req = 1'b0;
    e_m0_ack = 1'b0; e_m1_ack = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!m0_req || e_m0_ack) begin
        m0_req = ($urandom_range(0, 3) != 0);
        m0_addr = rand_addr();
      end
      if (!m1_req || e_m1_ack) begin
        m1_req = ($urandom_range(0, 3) != 0);
        m1_addr = rand_addr();
        m1_we = $urandom_range(0, 1) == 1;
        m1_wdata = $urandom;
        m1_ubhw = ut[$urandom_range(0, 4)];
      end
      model_edge();
      checks++;
      if (m0_ack !== e_m0_ack || m1_ack !== e_m1_ack) begin
        $display("FAIL rand_ack[%0d] got %0h%0h want %0h%0h", n, m0_ack, m1_ack, e_m0_ack, e_m1_ack);
        errors++;
      end
      checks++;
      if (ram_we !== e_ram_we || ram_addr !== e_ram_addr) begin
        $display("FAIL rand_ram[%0d] got we=%0h addr=%0h want we=%0h addr=%0h", n, ram_we, ram_addr, e_ram_we, e_ram_addr);
        errors++;
      end
      checks++;
      if (m0_rdata !== e_m0_rdata || m1_rdata !== e_m1_rdata) begin
        $display("FAIL rand_rdata[%0d] got %0h/%0h want %0h/%0h", n, m0_rdata, m1_rdata, e_m0_rdata, e_m1_rdata);
        errors++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    model_edge();
  endtask

  initial begin
    for (int unsigned i = 0; i < 1024; i++) mdl_mem[i] = init_byte(i);
    test_reset();
    test_m0_only();
    test_store_load();
    test_contention();
    test_idle_return();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got still running want finished");
    $fatal(1, "timeout");
  end

endmodule
